pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_ctrl_prio_enc.sv | 23 ++
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding, default depth
// and stage-index constants.
package pipe_ctrl_pkg;

  localparam int NSTAGE_DEF = 6;
  localparam int StallBus   = NSTAGE_DEF;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_prio_enc.sv
// Highest-set-bit priority encoder; the most downstream stalling stage wins.
module prio_enc #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    // Ascending scan so a later (higher) set bit overwrites earlier ones.
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/bubble generation and exception flush FSM.
// Optional saturating perf counters are enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE       = StallBus,
  parameter int FLUSH_CYCLES = 1,
  parameter int PC_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              except_req,
  input  logic [PC_W-1:0]   except_pc,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic [NSTAGE-1:0] flush,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_events
`endif
);

  localparam int         IDX_W    = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IDX_W-1:0]  hi_idx;
  logic              hi_any;

  prio_enc #(
    .N     (NSTAGE),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req_i (stallreq),
    .idx_o (hi_idx),
    .any_o (hi_any)
  );

  always_comb begin
    int k;
    k              = int'(hi_idx);
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    stall          = '0;
    bubble         = '0;
    flush          = '0;
    redirect_valid = 1'b0;
    busy           = 1'b0;
    // Outputs stay quiet while rst is low; the register block handles reset state.
    if (rst) begin
      case (state_q)
        ST_RUN: begin
          if (except_req) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_LOAD;
            pc_d    = except_pc;
          end else if (hi_any) begin
            for (int i = 0; i < NSTAGE; i++) begin
              if (i <= k)     stall[i]  = 1'b1;
              if (i == k + 1) bubble[i] = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          flush          = '1;
          busy           = 1'b1;
          // Counter sits at its load value only in the first cycle of a (re)started flush.
          redirect_valid = (cnt_q == CNT_LOAD);
          if (except_req) begin
            cnt_d = CNT_LOAD;
            pc_d  = except_pc;
          end else if (cnt_q == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign redirect_pc = pc_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_events_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if ((|stall) && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (except_req && (flush_events_q != '1)) flush_events_q <= flush_events_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule
